// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// Request is held until a single-cycle ack; read data is valid in the ack cycle.
interface lsu_mem_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: datapath memory port to req/ack bus, with byte lanes and load extension.
// Latency: accept -> BUSY until ack -> RESP retire cycle (min 2 stall cycles); stall holds the core meanwhile.
// Backpressure: memory stretches BUSY by withholding ack; LSU_TIMEOUT_EN adds an abort after TIMEOUT_CYCLES.
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_rd,
    input  logic                 mem_wr,
    input  logic [2:0]           funct3,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic                 stall,
    output logic                 fault,
    lsu_mem_ctrl_if.master       bus
);

    if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic        we_q;

    logic        start;
    logic        is_st;
    logic        size_ok;
    logic        align_ok;
    logic        legal;
    logic [3:0]  be_n;
    logic [31:0] wd_n;
    logic [31:0] lane;
    logic [31:0] fmt;

`ifdef LSU_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             to_q;
    assign cnt_inc = cnt + 1'b1;
`endif

    // A simultaneous rd+wr is decoded as a store.
    always_comb begin
        start    = mem_rd | mem_wr;
        is_st    = mem_wr;
        size_ok  = is_st ? (funct3 inside {3'b000, 3'b001, 3'b010})
                         : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        align_ok = 1'b1;
        if (funct3[1:0] == 2'b01)
            align_ok = ~addr[0];
        else if (funct3[1:0] == 2'b10)
            align_ok = (addr[1:0] == 2'b00);
        legal    = size_ok & align_ok;

        be_n = 4'b1111;
        wd_n = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_n = 4'b0001 << addr[1:0];
                wd_n = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_n = 4'b0011 << addr[1:0];
                wd_n = {2{wdata[15:0]}};
            end
            default: ;
        endcase

        lane = bus.bus_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  fmt = {{24{lane[7]}}, lane[7:0]};
            3'b001:  fmt = {{16{lane[15]}}, lane[15:0]};
            3'b100:  fmt = {24'd0, lane[7:0]};
            3'b101:  fmt = {16'd0, lane[15:0]};
            default: fmt = lane;
        endcase
    end

    assign stall = ((state == IDLE) & start & legal) | (state == BUSY);
`ifdef LSU_TIMEOUT_EN
    assign fault = ((state == IDLE) & start & ~legal) | to_q;
`else
    assign fault = (state == IDLE) & start & ~legal;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rdata         <= 32'd0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'd0;
            bus.bus_wdata <= 32'd0;
            bus.bus_be    <= 4'd0;
            off_q         <= 2'd0;
            f3_q          <= 3'd0;
            we_q          <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt           <= '0;
            to_q          <= 1'b0;
`endif
        end else begin
`ifdef LSU_TIMEOUT_EN
            to_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start && legal) begin
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= is_st;
                        bus.bus_addr  <= {addr[31:2], 2'b00};
                        bus.bus_be    <= is_st ? be_n : 4'b0000;
                        bus.bus_wdata <= wd_n;
                        off_q         <= addr[1:0];
                        f3_q          <= funct3;
                        we_q          <= is_st;
`ifdef LSU_TIMEOUT_EN
                        cnt           <= '0;
`endif
                        state         <= BUSY;
                    end else if (start && !is_st) begin
                        rdata <= 32'd0;
                    end
                end
                BUSY: begin
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        if (!we_q)
                            rdata <= fmt;
                        state <= RESP;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                        bus.bus_req <= 1'b0;
                        if (!we_q)
                            rdata <= 32'd0;
                        to_q  <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt <= cnt_inc;
                    end
`endif
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: stores, load formatting, faults, reset mid-access, back-to-back, timeout.
module tb_lsu_mem_ctrl;

`ifdef LSU_TIMEOUT_EN
    localparam int TO_CYC = 4;
`else
    localparam int TO_CYC = 255;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        fault;

    lsu_mem_ctrl_if bus_if ();

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(TO_CYC), .CNT_W(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .mem_rd (mem_rd),
        .mem_wr (mem_wr),
        .funct3 (funct3),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .stall  (stall),
        .fault  (fault),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int          stalls;
    int          busy_cyc;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_be;
    logic        c_we;
    logic        got_resp;
    logic        resp_fault;

    // Runs one legal access from IDLE (entered at posedge+1); memory acks in the ack_dly-th BUSY cycle (0 = never).
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int ack_dly, input logic [31:0] rdat);
        int busy;
        busy = 0;
        stalls = 0;
        got_resp = 1'b0;
        resp_fault = 1'b0;
        mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
        for (int c = 0; c < 40 && !got_resp; c++) begin
            #2;
            if (bus_if.bus_req) begin
                busy++;
                c_addr = bus_if.bus_addr; c_wdata = bus_if.bus_wdata;
                c_be = bus_if.bus_be; c_we = bus_if.bus_we;
                if (busy == ack_dly) begin
                    bus_if.bus_ack = 1'b1;
                    bus_if.bus_rdata = rdat;
                end
            end else if (c > 0) begin
                got_resp = 1'b1;
                resp_fault = fault;
            end
            if (stall) stalls++;
            @(posedge clk); #1;
            bus_if.bus_ack = 1'b0;
        end
        mem_rd = 1'b0; mem_wr = 1'b0;
        busy_cyc = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; funct3 = 3'b000;
        addr = 32'd0; wdata = 32'd0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        total++; if (bus_if.bus_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", bus_if.bus_req); end
        total++; if (bus_if.bus_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", bus_if.bus_we); end
        total++; if (bus_if.bus_addr !== 32'd0) begin bad++; $display("FAIL reset_addr got=%h exp=0", bus_if.bus_addr); end
        total++; if (bus_if.bus_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", bus_if.bus_wdata); end
        total++; if (bus_if.bus_be !== 4'd0) begin bad++; $display("FAIL reset_be got=%b exp=0", bus_if.bus_be); end
        total++; if (fault !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL reset_fault_stall got=%b%b exp=00", fault, stall); end
        reset = 1'b0;
        // stray ack while idle must be ignored
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0;
        total++; if (rdata !== 32'd0 || bus_if.bus_req !== 1'b0) begin bad++; $display("FAIL idle_ack got rdata=%h req=%b exp 0/0", rdata, bus_if.bus_req); end
    endtask

    task automatic test_store_word();
        run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'h1234_5678, 2, 32'd0);
        total++; if (got_resp !== 1'b1) begin bad++; $display("FAIL sw_resp got=%b exp=1", got_resp); end
        total++; if (stalls !== 3) begin bad++; $display("FAIL sw_stall got=%0d exp=3", stalls); end
        total++; if (c_addr !== 32'h100) begin bad++; $display("FAIL sw_addr got=%h exp=100", c_addr); end
        total++; if (c_be !== 4'b1111 || c_we !== 1'b1) begin bad++; $display("FAIL sw_be_we got=%b/%b exp=1111/1", c_be, c_we); end
        total++; if (c_wdata !== 32'h1234_5678) begin bad++; $display("FAIL sw_wdata got=%h exp=12345678", c_wdata); end
        total++; if (resp_fault !== 1'b0) begin bad++; $display("FAIL sw_fault got=%b exp=0", resp_fault); end
    endtask

    task automatic test_store_lanes();
        run_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_00AB, 1, 32'd0);
        total++; if (c_be !== 4'b1000) begin bad++; $display("FAIL sb_be got=%b exp=1000", c_be); end
        total++; if (c_wdata !== 32'hABAB_ABAB) begin bad++; $display("FAIL sb_wdata got=%h exp=ababab", c_wdata); end
        total++; if (c_addr !== 32'h100) begin bad++; $display("FAIL sb_addr got=%h exp=100", c_addr); end
        run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234_CDEF, 1, 32'd0);
        total++; if (c_be !== 4'b1100) begin bad++; $display("FAIL sh_be got=%b exp=1100", c_be); end
        total++; if (c_wdata !== 32'hCDEF_CDEF) begin bad++; $display("FAIL sh_wdata got=%h exp=cdefcdef", c_wdata); end
        total++; if (stalls !== 2) begin bad++; $display("FAIL sh_stall got=%0d exp=2", stalls); end
    endtask

    task automatic test_load_format();
        logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
        logic [31:0] as  [6] = '{32'h102, 32'h102, 32'h102, 32'h102, 32'h100, 32'h101};
        int          dl  [6] = '{1, 2, 1, 3, 1, 1};
        logic [31:0] ex  [6] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF,
                                 32'h0000_80FF, 32'h80FF_7F01, 32'h0000_007F};
        for (int i = 0; i < 6; i++) begin
            run_access(1'b1, 1'b0, f3s[i], as[i], 32'hDEAD_0000, dl[i], 32'h80FF_7F01);
            total++; if (rdata !== ex[i]) begin bad++; $display("FAIL load%0d_rdata got=%h exp=%h", i, rdata, ex[i]); end
            total++; if (stalls !== dl[i] + 1) begin bad++; $display("FAIL load%0d_stall got=%0d exp=%0d", i, stalls, dl[i] + 1); end
            total++; if (c_be !== 4'b0000 || c_we !== 1'b0 || c_addr !== 32'h100) begin
                bad++; $display("FAIL load%0d_bus got be=%b we=%b addr=%h exp 0000/0/100", i, c_be, c_we, c_addr);
            end
        end
    endtask

    task automatic test_rdata_hold();
        run_access(1'b0, 1'b1, 3'b010, 32'h200, 32'hCAFE_F00D, 1, 32'h1111_1111);
        repeat (2) @(posedge clk);
        #1;
        total++; if (rdata !== 32'h0000_007F) begin bad++; $display("FAIL hold_rdata got=%h exp=7f", rdata); end
    endtask

    task automatic test_faults();
        // misaligned halfword store
        mem_wr = 1'b1; funct3 = 3'b001; addr = 32'h101; wdata = 32'h5555;
        #1;
        total++; if (fault !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL sh_mis got fault=%b stall=%b exp 1/0", fault, stall); end
        @(posedge clk); #1;
        total++; if (bus_if.bus_req !== 1'b0) begin bad++; $display("FAIL sh_mis_req got=%b exp=0", bus_if.bus_req); end
        total++; if (rdata !== 32'h7F) begin bad++; $display("FAIL sh_mis_rdata got=%h exp=7f", rdata); end
        mem_wr = 1'b0;
        #1;
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL fault_clear got=%b exp=0", fault); end
        // rd+wr with a load-only code decodes as an illegal store
        mem_rd = 1'b1; mem_wr = 1'b1; funct3 = 3'b100; addr = 32'h100;
        #1;
        total++; if (fault !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL rdwr_st got fault=%b stall=%b exp 1/0", fault, stall); end
        @(posedge clk); #1;
        total++; if (rdata !== 32'h7F || bus_if.bus_req !== 1'b0) begin bad++; $display("FAIL rdwr_st_after got rdata=%h req=%b exp 7f/0", rdata, bus_if.bus_req); end
        // misaligned word load
        mem_wr = 1'b0; funct3 = 3'b010; addr = 32'h101;
        #1;
        total++; if (fault !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL lw_mis got fault=%b stall=%b exp 1/0", fault, stall); end
        @(posedge clk); #1;
        total++; if (bus_if.bus_req !== 1'b0 || rdata !== 32'd0) begin bad++; $display("FAIL lw_mis_after got req=%b rdata=%h exp 0/0", bus_if.bus_req, rdata); end
        // illegal funct3 load
        funct3 = 3'b011; addr = 32'h100;
        #1;
        total++; if (fault !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL f3_011 got fault=%b stall=%b exp 1/0", fault, stall); end
        @(posedge clk); #1;
        total++; if (bus_if.bus_req !== 1'b0) begin bad++; $display("FAIL f3_011_req got=%b exp=0", bus_if.bus_req); end
        mem_rd = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        mem_rd = 1'b1; funct3 = 3'b010; addr = 32'h200;
        @(posedge clk); #1;
        mem_rd = 1'b0;
        total++; if (bus_if.bus_req !== 1'b1) begin bad++; $display("FAIL mid_busy_req got=%b exp=1", bus_if.bus_req); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (bus_if.bus_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL mid_reset got req=%b stall=%b exp 0/0", bus_if.bus_req, stall); end
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL mid_fault got=%b exp=0", fault); end
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0;
        total++; if (rdata !== 32'd0 || stall !== 1'b0) begin bad++; $display("FAIL mid_late_ack got rdata=%h stall=%b exp 0/0", rdata, stall); end
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 1'b0, 3'b101, 32'h100, 32'd0, 1, 32'h1111_2222);
        total++; if (rdata !== 32'h0000_2222) begin bad++; $display("FAIL b2b0_rdata got=%h exp=2222", rdata); end
        total++; if (bus_if.bus_req !== 1'b0) begin bad++; $display("FAIL b2b0_resp_sampled got req=%b exp=0", bus_if.bus_req); end
        run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 1, 32'h9900_0000);
        total++; if (rdata !== 32'h0000_0099) begin bad++; $display("FAIL b2b1_rdata got=%h exp=99", rdata); end
        total++; if (bus_if.bus_req !== 1'b0) begin bad++; $display("FAIL b2b1_resp_sampled got req=%b exp=0", bus_if.bus_req); end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 1, 32'h55AA_55AA);
        total++; if (rdata !== 32'h55AA_55AA) begin bad++; $display("FAIL to_pre_rdata got=%h exp=55aa55aa", rdata); end
        run_access(1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 0, 32'd0);
        total++; if (got_resp !== 1'b1 || busy_cyc !== 4) begin bad++; $display("FAIL to_busy got resp=%b busy=%0d exp 1/4", got_resp, busy_cyc); end
        total++; if (resp_fault !== 1'b1) begin bad++; $display("FAIL to_fault got=%b exp=1", resp_fault); end
        total++; if (rdata !== 32'd0) begin bad++; $display("FAIL to_rdata got=%h exp=0", rdata); end
        total++; if (fault !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL to_idle got fault=%b stall=%b exp 0/0", fault, stall); end
    endtask
`endif

    initial begin
        test_reset();
        test_store_word();
        test_store_lanes();
        test_load_format();
        test_rdata_hold();
        test_faults();
        test_reset_mid();
        test_back_to_back();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
